aes_cipher_top: RTL and testbench
=================================

// Module: aes_cipher_top
// PURPOSE
//  Iterative AES-128 encryption core (FIPS-197), one round per clock, on-the-fly key expansion.
//  Loads a 128-bit plaintext and key on ld, pulses done when the ciphertext is ready.
//  Standalone crypto datapath block; no decrypt path, no chaining modes.
// PARAMETERS
//  none (AES-128 only: Nk=4, Nr=10 fixed)
// PORTS
//  clk       in   1    system clock, all state updates on rising edge
//  rst       in   1    reset, synchronous, active-low
//  ld        in   1    load strobe; samples key/text_in, starts encryption
//  key       in   128  cipher key, sampled only when ld=1
//  text_in   in   128  plaintext, sampled only when ld=1
//  text_out  out  128  ciphertext, registered
//  done      out  1    one-cycle pulse: text_out valid
// BEHAVIOUR
//  - Byte order: bit [127:120] is state byte 0 (row0,col0); column-major as in FIPS-197.
//  - Reset is sampled at posedge with rst=0. Effects: done=0, text_out=0, round counter idle.
//    Reset overrides ld and aborts any encryption in progress.
//  - Cycle L: ld=1 sampled.
//    - state <= text_in ^ key; round-key reg <= key; counter <= 10; busy=1.
//  - Cycles L+1..L+10: one round per cycle.
//    - Round key: w = prev rk; temp = SubWord(RotWord(w[31:0])) ^ Rcon.
//    - Rcon sequence: 01,02,04,08,10,20,40,80,1b,36 in byte [31:24].
//    - Rounds 1-9: SubBytes, ShiftRows, MixColumns, AddRoundKey.
//    - Round 10: no MixColumns.
//  - Cycle L+11: text_out <= final state; done=1 for exactly this cycle.
//    - busy clears; counter returns to idle.
//  - Latency: done rises 11 clocks after the ld sample edge.
//  - text_out holds its value until the next completion or reset.
//    A new ld does not clear text_out.
//  - done stays 0 while idle; done never asserts twice per load.
//  - key/text_in changes while busy: ignored (held internally).
//  - ld while idle: always starts.
//  - ld held high for several cycles: each sampled ld restarts (see CONFIGURATION).
//  - S-box: combinational 256x8 lookup.
//    - 16 instances for the state plus 4 for key expansion.
//  - xtime: {b[6:0],1'b0} ^ (b[7] ? 8'h1b : 8'h00).
// CONFIGURATION
//  AES_LD_IGNORE_BUSY_EN
//  - defined: ld asserted while busy (cycles L+1..L+10) is ignored.
//    - The current encryption completes normally.
//  - undefined (default): ld while busy aborts the current operation.
//    - Reloads from the new key/text_in; done for the aborted block never pulses.
// TESTING
//  - Reset: rst=0 for 2 clocks, then rst=1 -> done=0, text_out=0, no done pulse while idle.
//  - FIPS-197 C.1: key=000102030405060708090a0b0c0d0e0f,
//    pt=00112233445566778899aabbccddeeff -> text_out=69c4e0d86a7b0430d8cdb78070b4c55a.
//    - done pulses one cycle, 11 clocks after ld.
//  - FIPS-197 App.B: key=2b7e151628aed2a6abf7158809cf4f3c, pt=3243f6a8885a308d313198a2e0370734
//    -> 3925841d02dc09fbdc118597196a0b32.
//  - SP800-38A ECB: key=2b7e151628aed2a6abf7158809cf4f3c, pt=6bc1bee22e409f96e93d7e117393172a
//    -> 3ad77bb40d7a3660a89ecaf32466ef97.
//    - Run back-to-back with a 5-clock gap after done.
//    - The prior text_out holds until the new done.
//  - Mid-op: ld at L, then ld again at L+4 with C.1 vectors.
//    - Default build: single done at L+15 with the C.1 result.
//    - With AES_LD_IGNORE_BUSY_EN: done at L+11 with the first block's result.
//  - Reset mid-op: rst=0 at L+5 -> no done pulse, text_out=0.

Source files
------------

// File: rtl/aes_cipher_top.sv
// Iterative AES-128 encryption core, one round per clock, on-the-fly key schedule.
// Optional macro AES_LD_IGNORE_BUSY_EN: ignore ld while a block is in flight.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // entry a lives at bits [2047-8a -: 8]
  assign y = TBL[{~a, 3'b111} -: 8];
endmodule

module aes_cipher_top (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [127:0] key,
  input  logic [127:0] text_in,
  output logic [127:0] text_out,
  output logic         done
);
  logic [127:0] state_q;
  logic [127:0] rk_q;
  logic [127:0] rk_nxt;
  logic [127:0] sb_out;
  logic [127:0] sr_out;
  logic [127:0] mc_out;
  logic [127:0] rnd_out;
  logic [3:0]   cnt_q;
  logic         busy_q;
  logic         fin_q;
  logic         ld_go;
  logic [7:0]   rcon;
  logic [31:0]  rot_w;
  logic [31:0]  sub_w;
  logic [31:0]  temp_w;
  logic [31:0]  w0;
  logic [31:0]  w1;
  logic [31:0]  w2;
  logic [31:0]  w3;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3, t;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    t  = a0 ^ a1 ^ a2 ^ a3;
    mix_col = {a0 ^ t ^ xtime(a0 ^ a1),
               a1 ^ t ^ xtime(a1 ^ a2),
               a2 ^ t ^ xtime(a2 ^ a3),
               a3 ^ t ^ xtime(a3 ^ a0)};
  endfunction

`ifdef AES_LD_IGNORE_BUSY_EN
  assign ld_go = ld & ~busy_q;
`else
  assign ld_go = ld;
`endif

  // counter runs 10..1 while busy, so it indexes Rcon directly
  always_comb begin
    rcon = 8'h00;
    case (cnt_q)
      4'd10:   rcon = 8'h01;
      4'd9:    rcon = 8'h02;
      4'd8:    rcon = 8'h04;
      4'd7:    rcon = 8'h08;
      4'd6:    rcon = 8'h10;
      4'd5:    rcon = 8'h20;
      4'd4:    rcon = 8'h40;
      4'd3:    rcon = 8'h80;
      4'd2:    rcon = 8'h1b;
      4'd1:    rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign rot_w = {rk_q[23:0], rk_q[31:24]};

  genvar gi, gc, gr;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ksb
      aes_sbox u_sb (
        .a(rot_w[31-8*gi -: 8]),
        .y(sub_w[31-8*gi -: 8])
      );
    end
    for (gi = 0; gi < 16; gi++) begin : g_ssb
      aes_sbox u_sb (
        .a(state_q[127-8*gi -: 8]),
        .y(sb_out[127-8*gi -: 8])
      );
    end
    for (gc = 0; gc < 4; gc++) begin : g_col
      for (gr = 0; gr < 4; gr++) begin : g_row
        assign sr_out[127-8*(4*gc+gr) -: 8] =
          sb_out[127-8*(4*((gc+gr)%4)+gr) -: 8];
      end
      assign mc_out[127-32*gc -: 32] = mix_col(sr_out[127-32*gc -: 32]);
    end
  endgenerate

  assign temp_w = sub_w ^ {rcon, 24'h000000};
  assign w0     = rk_q[127:96] ^ temp_w;
  assign w1     = rk_q[95:64] ^ w0;
  assign w2     = rk_q[63:32] ^ w1;
  assign w3     = rk_q[31:0] ^ w2;
  assign rk_nxt = {w0, w1, w2, w3};

  assign rnd_out = ((cnt_q == 4'd1) ? sr_out : mc_out) ^ rk_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= '0;
      rk_q     <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      fin_q    <= 1'b0;
      text_out <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (fin_q) begin
        text_out <= state_q;
        done     <= 1'b1;
        fin_q    <= 1'b0;
      end
      if (ld_go) begin
        state_q <= text_in ^ key;
        rk_q    <= key;
        cnt_q   <= 4'd10;
        busy_q  <= 1'b1;
        fin_q   <= 1'b0;
      end else if (busy_q) begin
        state_q <= rnd_out;
        rk_q    <= rk_nxt;
        cnt_q   <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          busy_q <= 1'b0;
          fin_q  <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_aes_cipher_top.sv
// Directed-vector bench for aes_cipher_top using FIPS-197 and SP800-38A vectors.

module tb_aes_cipher_top;
  logic         clk;
  logic         rst;
  logic         ld;
  logic [127:0] key;
  logic [127:0] text_in;
  logic [127:0] text_out;
  logic         done;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K_AB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_AB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C_AB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] P_ECB = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] C_ECB = 128'h3ad77bb40d7a3660a89ecaf32466ef97;

  aes_cipher_top dut (
    .clk(clk),
    .rst(rst),
    .ld(ld),
    .key(key),
    .text_in(text_in),
    .text_out(text_out),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ends at the negedge just after the ld sample edge
  task automatic load(input logic [127:0] k, input logic [127:0] p);
    @(negedge clk);
    ld      = 1'b1;
    key     = k;
    text_in = p;
    @(negedge clk);
    ld = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = -1;
    for (int k = 1; k <= limit; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int pulses;
    rst = 1'b0;
    ld  = 1'b0;
    key = '0;
    text_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got %b exp 0", done);
    end
    checks++;
    if (text_out !== 128'h0) begin
      errors++;
      $display("FAIL reset_text got %h exp 0", text_out);
    end
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL idle_done got %0d pulses exp 0", pulses);
    end
  endtask

  task automatic test_c1;
    int cyc;
    load(K_C1, P_C1);
    key     = 128'hdeadbeef_00000000_ffffffff_12345678;
    text_in = 128'h0123456789abcdef_fedcba9876543210;
    wait_done(30, cyc);
    checks++;
    if (cyc !== 11) begin
      errors++;
      $display("FAIL c1_latency got %0d exp 11", cyc);
    end
    checks++;
    if (text_out !== C_C1) begin
      errors++;
      $display("FAIL c1_text got %h exp %h", text_out, C_C1);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL c1_pulse_width got %b exp 0", done);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit held_ok;
    load(K_AB, P_AB);
    wait_done(30, cyc);
    checks++;
    if (cyc !== 11 || text_out !== C_AB) begin
      errors++;
      $display("FAIL appb got %h lat %0d exp %h lat 11", text_out, cyc, C_AB);
    end
    repeat (5) @(negedge clk);
    load(K_AB, P_ECB);
    held_ok = 1'b1;
    if (text_out !== C_AB) held_ok = 1'b0;
    cyc = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cyc = k;
        break;
      end
      if (text_out !== C_AB) held_ok = 1'b0;
    end
    checks++;
    if (!held_ok) begin
      errors++;
      $display("FAIL b2b_hold got %h exp %h", text_out, C_AB);
    end
    checks++;
    if (cyc !== 11) begin
      errors++;
      $display("FAIL ecb_latency got %0d exp 11", cyc);
    end
    checks++;
    if (text_out !== C_ECB) begin
      errors++;
      $display("FAIL ecb_text got %h exp %h", text_out, C_ECB);
    end
  endtask

  task automatic test_mid_op;
    int first;
    int pulses;
    int exp_first;
    logic [127:0] exp_text;
    int k;
`ifdef AES_LD_IGNORE_BUSY_EN
    exp_first = 11;
    exp_text  = C_AB;
`else
    exp_first = 15;
    exp_text  = C_C1;
`endif
    repeat (3) @(negedge clk);
    load(K_AB, P_AB);
    first  = -1;
    pulses = 0;
    k      = 0;
    repeat (3) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
      end
    end
    ld      = 1'b1;
    key     = K_C1;
    text_in = P_C1;
    @(negedge clk);
    k++;
    ld = 1'b0;
    if (done === 1'b1) begin
      pulses++;
      if (first < 0) first = k;
    end
    repeat (21) begin
      @(negedge clk);
      k++;
      if (done === 1'b1) begin
        pulses++;
        if (first < 0) first = k;
        if (k == exp_first && text_out !== exp_text) begin
          checks++;
          errors++;
          $display("FAIL midop_text got %h exp %h", text_out, exp_text);
        end else if (k == exp_first) begin
          checks++;
        end
      end
    end
    checks++;
    if (first !== exp_first) begin
      errors++;
      $display("FAIL midop_latency got %0d exp %0d", first, exp_first);
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL midop_pulses got %0d exp 1", pulses);
    end
  endtask

  task automatic test_reset_mid_op;
    int pulses;
    load(K_C1, P_C1);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL rstmid_pulses got %0d exp 0", pulses);
    end
    checks++;
    if (text_out !== 128'h0) begin
      errors++;
      $display("FAIL rstmid_text got %h exp 0", text_out);
    end
  endtask

  initial begin
    test_reset;
    test_c1;
    test_back_to_back;
    test_mid_op;
    test_reset_mid_op;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
